norm_lzc_pipe: RTL and testbench

- Pipelined normalisation front-end for the perceptron datapath; sits directly upstream of the 16-bit low-fan-in left shifter.
- Accepts a 16-bit unsigned mantissa plus exponent over valid/ready and counts leading zeros.
- Produces the shifter's data and its 4-bit select, with the select limited by the available exponent, together with the adjusted exponent.
- Outputs are registered and held stable under back-pressure.

---
 rtl/norm_pkg.sv | 17 +
 rtl/norm_lzc_pipe_lzc16.sv | 41 ++++
 rtl/norm_lzc_pipe.sv | 103 ++++++++++
 tb/tb_norm_lzc_pipe.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/norm_pkg.sv
// rtl/norm_pkg.sv - shared widths, select weights and shift-to-select mapping
package norm_pkg;

  localparam int D_WIDTH   = 16;
  localparam int SEL_WIDTH = 4;

  // Shift weight contributed by each select bit of the downstream shifter
  localparam int SEL0_WEIGHT = 8;
  localparam int SEL1_WEIGHT = 4;
  localparam int SEL2_WEIGHT = 2;
  localparam int SEL3_WEIGHT = 1;

  function automatic logic [SEL_WIDTH-1:0] sel_of(input logic [3:0] sh);
    return {sh[0], sh[1], sh[2], sh[3]};
  endfunction

endpackage

// File: rtl/norm_lzc_pipe_lzc16.sv
// rtl/norm_lzc_pipe_lzc16.sv - combinational 16-bit leading-zero counter, 4-level tree
module lzc16 (
  input  logic [15:0] data,
  output logic [4:0]  count
);

  // Each node carries "any bit set" and the zero count within its span
  logic [7:0]      v1;
  logic [7:0]      c1;
  logic [3:0]      v2;
  logic [3:0][1:0] c2;
  logic [1:0]      v3;
  logic [1:0][2:0] c3;
  logic            v4;
  logic [3:0]      c4;

  always_comb begin
    v1 = '0;
    c1 = '0;
    v2 = '0;
    c2 = '0;
    v3 = '0;
    c3 = '0;
    for (int i = 0; i < 8; i++) begin
      v1[i] = data[2*i+1] | data[2*i];
      c1[i] = ~data[2*i+1];
    end
    for (int i = 0; i < 4; i++) begin
      v2[i] = v1[2*i+1] | v1[2*i];
      c2[i] = v1[2*i+1] ? {1'b0, c1[2*i+1]} : {1'b1, c1[2*i]};
    end
    for (int i = 0; i < 2; i++) begin
      v3[i] = v2[2*i+1] | v2[2*i];
      c3[i] = v2[2*i+1] ? {1'b0, c2[2*i+1]} : {1'b1, c2[2*i]};
    end
    v4    = v3[1] | v3[0];
    c4    = v3[1] ? {1'b0, c3[1]} : {1'b1, c3[0]};
    count = v4 ? {1'b0, c4} : 5'd16;
  end

endmodule

// File: rtl/norm_lzc_pipe.sv
// rtl/norm_lzc_pipe.sv - two-stage normalisation front-end; NORM_STAT_EN adds transfer counters
module norm_lzc_pipe
  import norm_pkg::*;
#(
  parameter int EXP_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [D_WIDTH-1:0]   in_data,
  input  logic [EXP_WIDTH-1:0] in_exp,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [D_WIDTH-1:0]   out_x,
  output logic [SEL_WIDTH-1:0] out_sel,
  output logic [EXP_WIDTH-1:0] out_exp,
  output logic                 out_zero
`ifdef NORM_STAT_EN
  ,
  output logic [15:0]          stat_xfer_cnt,
  output logic [15:0]          stat_zero_cnt
`endif
);

  logic                 s1_valid;
  logic [D_WIDTH-1:0]   s1_data;
  logic [EXP_WIDTH-1:0] s1_exp;
  logic [4:0]           lzc;
  logic                 is_zero;
  logic [3:0]           sh;
  logic                 s2_adv;
  logic                 s1_adv;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_adv;
  assign in_ready = !s1_valid || s2_adv;

  lzc16 u_lzc (
    .data  (s1_data),
    .count (lzc)
  );

  // Shift is capped by the exponent so out_exp can never wrap below zero
  always_comb begin
    is_zero = (lzc == 5'd16);
    sh      = '0;
    if (!is_zero) begin
      if (EXP_WIDTH'(lzc) < s1_exp) sh = lzc[3:0];
      else                          sh = s1_exp[3:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_exp   <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= in_data;
        s1_exp  <= in_exp;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_x     <= '0;
      out_sel   <= '0;
      out_exp   <= '0;
      out_zero  <= 1'b0;
    end else begin
      if (s2_adv) out_valid <= s1_valid;
      if (s1_adv) begin
        out_x    <= s1_data;
        out_sel  <= sel_of(sh);
        out_exp  <= is_zero ? '0 : s1_exp - EXP_WIDTH'(sh);
        out_zero <= is_zero;
      end
    end
  end

`ifdef NORM_STAT_EN
  logic xfer;
  assign xfer = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_xfer_cnt <= '0;
      stat_zero_cnt <= '0;
    end else begin
      if (xfer && stat_xfer_cnt != 16'hFFFF) stat_xfer_cnt <= stat_xfer_cnt + 16'd1;
      if (xfer && out_zero && stat_zero_cnt != 16'hFFFF) stat_zero_cnt <= stat_zero_cnt + 16'd1;
    end
  end
`else
  // Statistics hardware is not built in this configuration
`endif

endmodule

// File: tb/tb_norm_lzc_pipe.sv
// tb/tb_norm_lzc_pipe.sv - randomized scoreboard bench for norm_lzc_pipe
module tb_norm_lzc_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [5:0]  in_exp;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_x;
  logic [3:0]  out_sel;
  logic [5:0]  out_exp;
  logic        out_zero;
`ifdef NORM_STAT_EN
  logic [15:0] stat_xfer_cnt;
  logic [15:0] stat_zero_cnt;
`endif

  int total = 0;
  int bad   = 0;

  logic [26:0] exp_q[$];
  logic        prev_hold = 1'b0;
  logic [26:0] prev_out;

  norm_lzc_pipe #(.EXP_WIDTH(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_exp    (in_exp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_sel   (out_sel),
    .out_exp   (out_exp),
    .out_zero  (out_zero)
`ifdef NORM_STAT_EN
    ,
    .stat_xfer_cnt (stat_xfer_cnt),
    .stat_zero_cnt (stat_zero_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Reference: find first one from the MSB, cap by exponent, decompose shift into weights 8/4/2/1
  function automatic logic [26:0] model(input logic [15:0] d, input logic [5:0] e);
    int lz;
    int sh;
    logic [3:0] sel;
    if (d == 16'h0) return {16'h0, 4'h0, 6'h0, 1'b1};
    lz = 0;
    while (d[15-lz] == 1'b0) lz++;
    sh = (lz < int'(e)) ? lz : int'(e);
    sel[0] = ((sh / 8) % 2) != 0;
    sel[1] = ((sh / 4) % 2) != 0;
    sel[2] = ((sh / 2) % 2) != 0;
    sel[3] = (sh % 2) != 0;
    return {d, sel, 6'(int'(e) - sh), 1'b0};
  endfunction

  function automatic logic [15:0] shifted(input logic [15:0] x, input logic [3:0] sel);
    int amt;
    amt = 8 * int'(sel[0]) + 4 * int'(sel[1]) + 2 * int'(sel[2]) + int'(sel[3]);
    return x << amt;
  endfunction

  // Scoreboard and back-pressure stability monitor
  always @(negedge clk) begin
    logic [26:0] cur;
    logic [26:0] want;
    cur = {out_x, out_sel, out_exp, out_zero};
    if (!rst_n) begin
      exp_q.delete();
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) check("hold_stable", 32'(cur), 32'(prev_out));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 32'(cur), 32'h7FFFFFF);
        end else begin
          want = exp_q.pop_front();
          check("stream_out", 32'(cur), 32'(want));
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_data, in_exp));
      prev_hold = out_valid && !out_ready;
      prev_out  = cur;
    end
  end

  task automatic directed(input logic [15:0] d, input logic [5:0] e, input logic [3:0] w_sel,
                          input logic [5:0] w_exp, input logic w_zero, input logic [15:0] w_shift);
    in_valid = 1'b1;
    in_data  = d;
    in_exp   = e;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("lat_not_yet", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_valid", 32'(out_valid), 32'd1);
    check("dir_x", 32'(out_x), 32'(d));
    check("dir_sel", 32'(out_sel), 32'(w_sel));
    check("dir_exp", 32'(out_exp), 32'(w_exp));
    check("dir_zero", 32'(out_zero), 32'(w_zero));
    check("dir_shift", 32'(shifted(out_x, out_sel)), 32'(w_shift));
  endtask

  initial begin
    int sent;
    int guard;
    int seen;
    logic acc;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_exp    = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_x", 32'(out_x), 32'd0);
    check("rst_out_sel", 32'(out_sel), 32'd0);
    check("rst_out_exp", 32'(out_exp), 32'd0);
    check("rst_out_zero", 32'(out_zero), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    out_ready = 1'b1;
    directed(16'h0010, 6'd20, 4'b1101, 6'd9,  1'b0, 16'h8000);
    directed(16'h0010, 6'd10, 4'b0101, 6'd0,  1'b0, 16'h4000);
    directed(16'h0000, 6'd33, 4'b0000, 6'd0,  1'b1, 16'h0000);
    directed(16'h1234, 6'd0,  4'b0000, 6'd0,  1'b0, 16'h1234);
    directed(16'hF000, 6'd45, 4'b0000, 6'd45, 1'b0, 16'hF000);
    directed(16'h0001, 6'd63, 4'b1111, 6'd48, 1'b0, 16'h8000);

    // Back-pressure: two accepts fill both stages, then in_ready must drop
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h8000;
    in_exp    = 6'd31;
    @(posedge clk); #1;
    in_data = 16'h4000;
    @(posedge clk); #1;
    in_data = 16'h0001;
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("bp_in_ready_still_low", 32'(in_ready), 32'd0);
    check("bp_hold_x", 32'(out_x), 32'h8000);
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_back", 32'(in_ready), 32'd1);
    check("bp_w0_sel", 32'(out_sel), 32'd0);
    check("bp_w0_exp", 32'(out_exp), 32'd31);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_w1_x", 32'(out_x), 32'h4000);
    check("bp_w1_sel", 32'(out_sel), 32'b1000);
    check("bp_w1_exp", 32'(out_exp), 32'd30);
    @(posedge clk); #1;
    check("bp_w2_x", 32'(out_x), 32'h0001);
    check("bp_w2_sel", 32'(out_sel), 32'b1111);
    check("bp_w2_exp", 32'(out_exp), 32'd16);
    @(posedge clk); #1;
    check("bp_drained", 32'(out_valid), 32'd0);

    // Asynchronous reset with both stages occupied
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0100;
    in_exp    = 6'd12;
    @(posedge clk); #1;
    in_data = 16'h0200;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("ar_full_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_out_valid_now", 32'(out_valid), 32'd0);
    check("ar_in_ready_now", 32'(in_ready), 32'd1);
    @(posedge clk); #4;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("ar_no_stale", 32'(seen), 32'd0);

    // Randomized traffic with random gaps and back-pressure
    @(posedge clk); #1;
    sent  = 0;
    guard = 0;
    while (sent < 400 && guard < 20000) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      guard++;
      if (acc) sent++;
      if (acc || !in_valid) begin
        if (sent < 400 && ($urandom % 4) != 0) begin
          in_valid = 1'b1;
          in_data  = 16'($urandom) & (16'hFFFF >> $urandom_range(0, 16));
          in_exp   = 6'($urandom_range(0, 63));
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom % 4) != 0;
    end
    in_valid = 1'b0;
    check("rand_sent", 32'(sent), 32'd400);
    out_ready = 1'b1;
    guard = 0;
    while ((exp_q.size() != 0 || out_valid) && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("rand_drain", 32'(exp_q.size()), 32'd0);

`ifdef NORM_STAT_EN
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("stat_rst_xfer", 32'(stat_xfer_cnt), 32'd0);
    rst_n = 1'b1;
    in_valid = 1'b1;
    in_exp   = 6'd7;
    for (int i = 0; i < 5; i++) begin
      in_data = (i == 1 || i == 3) ? 16'h0000 : 16'(16'h0101 << i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("stat_xfer5", 32'(stat_xfer_cnt), 32'd5);
    check("stat_zero2", 32'(stat_zero_cnt), 32'd2);
    in_valid = 1'b1;
    in_data  = 16'h00F0;
    repeat (70000) @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("stat_xfer_sat", 32'(stat_xfer_cnt), 32'hFFFF);
    check("stat_zero_keep", 32'(stat_zero_cnt), 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
